program_loader: RTL
===================

Name: program_loader

Overview:
- Serial writer for the 16 x 8-bit TD4 program memory; the write-side counterpart of the memory's write port.
- Receives program bytes over a 2-wire synchronous serial link (`ser_sck`, `ser_sdi`) from an external host.
- Assembles each byte and drives the memory's address / opcode / immediate / write inputs, filling addresses 0..WORDS-1 in order.
- Holds the CPU (`cpu_hold`) while loading is in progress.

Parameters:
- `WORDS`, 16, number of bytes per load session (1..16); the session ends after `WORDS` writes.
- `SYNC_STAGES`, 2, synchroniser depth for `ser_sck` and `ser_sdi` (at least 2).
- `TIMEOUT`, 1023, number of `clk` cycles without an `ser_sck` rising edge after which a partial byte is discarded (1..1023).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `load_en`  in  1  host request: load session active while high
- `ser_sck`  in  1  serial bit clock, asynchronous; data is sampled on its rising edge
- `ser_sdi`  in  1  serial data, MSB first, asynchronous
- `mem_address`  out  4  memory write address
- `mem_opcode`  out  4  memory `opcode_in` (byte bits [3:0])
- `mem_immediate`  out  4  memory `immediate_in` (byte bits [7:4])
- `mem_write`  out  1  one-cycle memory write strobe
- `cpu_hold`  out  1  high while state is not IDLE or DONE
- `done`  out  1  high in DONE: all `WORDS` bytes have been written
- `error`  out  1  sticky: session aborted or byte timed out; cleared when a new session starts

Behaviour:
- Reset (`rst` high at a `clk` edge):
  - State is IDLE.
  - All outputs are 0.
  - Shift register, bit counter, address counter, timeout counter and synchroniser stages are cleared.
  - Reset mid-session discards all partial state; no `mem_write` pulse is issued in the cycle `rst` is asserted.
- Synchronisation:
  - `ser_sck` and `ser_sdi` each pass through `SYNC_STAGES` flip-flops.
  - A rising edge is detected when the synchronised `sck` is 1 and its previous value was 0.
  - `sdi` is sampled from the synchronised stage in the same cycle as the edge.
- FSM states:
  - IDLE:
    - `cpu_hold` = 0.
    - When `load_en` = 1, go to SHIFT; clear `error`, the address counter and the bit counter.
  - SHIFT:
    - `cpu_hold` = 1.
    - On each detected edge: `shreg` <= {`shreg[6:0]`, `sdi`}; bit counter += 1; timeout counter cleared.
    - On the 8th edge, go to WRITE.
    - With no edge, the timeout counter increments. When it reaches `TIMEOUT` with bit counter != 0: discard the partial byte (bit counter to 0), set `error`, stay in SHIFT.
    - Idle time with bit counter = 0 never times out.
  - WRITE (exactly 1 cycle):
    - `mem_write` = 1.
    - `mem_address` = address counter, `mem_immediate` = `shreg[7:4]`, `mem_opcode` = `shreg[3:0]`.
    - Next cycle: address counter += 1. If the address just written = `WORDS`-1, go to DONE; otherwise go to SHIFT.
  - DONE:
    - `done` = 1, `cpu_hold` = 0.
    - Serial edges are ignored.
    - When `load_en` = 0, go to IDLE and clear `done`.
- Latency:
  - `mem_write` is asserted in the cycle after the 8th detected edge.
  - That is `SYNC_STAGES` + 2 `clk` cycles after the 8th `ser_sck` rising edge reaches the first synchroniser flop.
- Output timing:
  - `mem_address`, `mem_opcode` and `mem_immediate` are registered and held stable outside WRITE (last written values remain).
  - `mem_write` is 0 in every state except WRITE.
- Abort:
  - `load_en` falling while in SHIFT or WRITE: go to IDLE next cycle and set `error`.
  - If this happens in WRITE, the write in progress still completes.
  - Memory contents written so far are not rolled back.
- Wrap: the address counter is 4 bits and never passes `WORDS`-1 because of the DONE transition. With `WORDS` = 16 the last address is 15.
- Host constraint: `ser_sck` high and low phases are each at least `SYNC_STAGES` + 1 `clk` periods; faster edges are undefined.
- Simultaneous edge and timeout in the same cycle: the edge takes priority and the timeout counter clears.
- `load_en` reasserted in the same cycle the FSM enters IDLE: the new session starts on the following cycle.

Decomposition:
- Shared package `td4_pkg`:
  - `ADDR_W` = 4, `WORD_W` = 8, `NIBBLE_W` = 4.
  - FSM state enum `loader_state_t` {IDLE, SHIFT, WRITE, DONE}.
- Sub-module `sync_edge`:
  - `SYNC_STAGES`-deep synchroniser for `sck` and `sdi`.
  - Outputs `sdi_s` and a one-cycle `sck_rise` pulse.
  - Instantiated once.

Test Plan:
- Full load: `WORDS` = 16, host sends bytes 0x00..0x0F → 16 `mem_write` pulses; address k carries `immediate` = 0, `opcode` = k; `done` = 1 after address 15; `cpu_hold` = 0 in DONE.
- Nibble order: single byte 0xB3 to address 0 → `mem_immediate` = 0xB, `mem_opcode` = 0x3; `mem_write` exactly 1 cycle, at `SYNC_STAGES` + 2 cycles after the 8th `sck` edge.
- Timeout: send 5 bits, stall `TIMEOUT` cycles, then send 0xA5 → `error` = 1, no write for the partial byte, next write carries 0xA5 at address 0.
- Abort: drop `load_en` after 3 full bytes plus 4 bits → exactly 3 writes (addresses 0..2), `error` = 1, state IDLE; re-raising `load_en` clears `error` and the next byte goes to address 0.
- Reset mid-byte: assert `rst` after 6 bits → all outputs 0 next cycle, no `mem_write` pulse; after release, a fresh byte 0x5C goes to address 0.
- Short session: `WORDS` = 2, bytes 0x11, 0x22 → writes at addresses 0 and 1, `done` = 1; further `sck` edges produce no writes until `load_en` = 0 → `done` = 0.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared widths and loader FSM state encoding for the TD4 program memory
// and its serial loader.
package td4_pkg;

    localparam int ADDR_W   = 4;
    localparam int WORD_W   = 8;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Write-side bus into the TD4 program memory: address, split byte and strobe.
interface program_loader_if;
    import td4_pkg::*;

    logic [ADDR_W-1:0]   mem_address;
    logic [NIBBLE_W-1:0] mem_opcode;
    logic [NIBBLE_W-1:0] mem_immediate;
    logic                mem_write;

    modport master (
        output mem_address,
        output mem_opcode,
        output mem_immediate,
        output mem_write
    );

    modport slave (
        input mem_address,
        input mem_opcode,
        input mem_immediate,
        input mem_write
    );
endinterface

// File: rtl/program_loader_sync_edge.sv
// Multi-stage synchroniser for the serial clock/data pair with a registered
// rising-edge pulse on the synchronised clock and data aligned to it.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic sdi,
    output logic sdi_s,
    output logic sck_rise
);

    logic [SYNC_STAGES-1:0] sck_pipe_reg;
    logic [SYNC_STAGES-1:0] sdi_pipe_reg;
    logic                   sck_prev_reg;
    logic                   sck_rise_reg;
    logic                   sdi_s_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sck_pipe_reg[gi] <= 1'b0;
                        sdi_pipe_reg[gi] <= 1'b0;
                    end else begin
                        sck_pipe_reg[gi] <= sck;
                        sdi_pipe_reg[gi] <= sdi;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sck_pipe_reg[gi] <= 1'b0;
                        sdi_pipe_reg[gi] <= 1'b0;
                    end else begin
                        sck_pipe_reg[gi] <= sck_pipe_reg[gi-1];
                        sdi_pipe_reg[gi] <= sdi_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Pulse and data are registered together so the FSM sees a matched pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev_reg <= 1'b0;
            sck_rise_reg <= 1'b0;
            sdi_s_reg    <= 1'b0;
        end else begin
            sck_prev_reg <= sck_pipe_reg[SYNC_STAGES-1];
            sck_rise_reg <= sck_pipe_reg[SYNC_STAGES-1] & ~sck_prev_reg;
            sdi_s_reg    <= sdi_pipe_reg[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_rise_reg;
    assign sdi_s    = sdi_s_reg;

endmodule

// File: rtl/program_loader.sv
// Serial loader for the 16 x 8-bit TD4 program memory: shifts in bytes MSB
// first, writes them to consecutive addresses and holds the CPU meanwhile.
module program_loader
    import td4_pkg::*;
#(
    parameter int WORDS       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             ser_sck,
    input  logic             ser_sdi,
    program_loader_if.master mem,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [9:0]        TOUT_LAST = 10'(TIMEOUT - 1);

    logic sdi_s;
    logic sck_rise;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .sck      (ser_sck),
        .sdi      (ser_sdi),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise)
    );

    loader_state_t       state_reg;
    logic [WORD_W-1:0]   shreg_reg;
    logic [2:0]          bit_cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [9:0]          tout_reg;
    logic [ADDR_W-1:0]   mem_address_reg;
    logic [NIBBLE_W-1:0] mem_opcode_reg;
    logic [NIBBLE_W-1:0] mem_immediate_reg;
    logic                mem_write_reg;
    logic                cpu_hold_reg;
    logic                done_reg;
    logic                error_reg;
    logic [WORD_W-1:0]   shreg_next;

    assign shreg_next = {shreg_reg[WORD_W-2:0], sdi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            shreg_reg         <= '0;
            bit_cnt_reg       <= '0;
            addr_reg          <= '0;
            tout_reg          <= '0;
            mem_address_reg   <= '0;
            mem_opcode_reg    <= '0;
            mem_immediate_reg <= '0;
            mem_write_reg     <= 1'b0;
            cpu_hold_reg      <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            mem_write_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        state_reg    <= SHIFT;
                        error_reg    <= 1'b0;
                        addr_reg     <= '0;
                        bit_cnt_reg  <= '0;
                        tout_reg     <= '0;
                        cpu_hold_reg <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!load_en) begin
                        state_reg    <= IDLE;
                        error_reg    <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else if (sck_rise) begin
                        shreg_reg   <= shreg_next;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        tout_reg    <= '0;
                        // Launch the write with the completed byte so the
                        // strobe is high for exactly the WRITE cycle.
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg         <= WRITE;
                            mem_write_reg     <= 1'b1;
                            mem_address_reg   <= addr_reg;
                            mem_immediate_reg <= shreg_next[7:4];
                            mem_opcode_reg    <= shreg_next[3:0];
                        end
                    end else if (bit_cnt_reg != 3'd0) begin
                        if (tout_reg == TOUT_LAST) begin
                            bit_cnt_reg <= '0;
                            tout_reg    <= '0;
                            error_reg   <= 1'b1;
                        end else begin
                            tout_reg <= tout_reg + 10'd1;
                        end
                    end
                end
                WRITE: begin
                    addr_reg <= addr_reg + 1'b1;
                    tout_reg <= '0;
                    if (!load_en) begin
                        state_reg    <= IDLE;
                        error_reg    <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else if (addr_reg == LAST_ADDR) begin
                        state_reg    <= DONE;
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else begin
                        state_reg <= SHIFT;
                    end
                end
                DONE: begin
                    if (!load_en) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem.mem_address   = mem_address_reg;
    assign mem.mem_opcode    = mem_opcode_reg;
    assign mem.mem_immediate = mem_immediate_reg;
    assign mem.mem_write     = mem_write_reg;
    assign cpu_hold          = cpu_hold_reg;
    assign done              = done_reg;
    assign error             = error_reg;

endmodule
